// File: rtl/roi_sequencer.sv
// Frame-level ROI sequencer: walks source pixel addresses, latches the ROI origin
// per frame (with optional horizontal auto-pan) and ping-pongs frame-buffer banks.
module roi_sequencer #(
    parameter int SRC_WIDTH          = 640,
    parameter int SRC_HEIGHT         = 480,
    parameter int IMG_WIDTH_MAX_LOG2 = 6
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          FRAME_START,
    input  logic                          PIX_VALID,
    input  logic [IMG_WIDTH_MAX_LOG2-1:0] IMAGE_WIDTH,
    input  logic [10:0]                   CFG_X0,
    input  logic [9:0]                    CFG_Y0,
    input  logic                          CFG_WE,
    input  logic                          PAN_EN,
    input  logic [3:0]                    PAN_STEP,
    input  logic                          BUF_RELEASE,
    output logic [10:0]                   ADDR_H,
    output logic [9:0]                    ADDR_V,
    output logic [10:0]                   ROI_X0,
    output logic [9:0]                    ROI_Y0,
    output logic                          BANK_SEL,
    output logic                          BANK_READY,
    output logic                          FRAME_ERR,
    output logic [7:0]                    DROP_CNT
);

    typedef enum logic [1:0] {IDLE, ACTIVE, SWAP_WAIT} state_t;

    state_t      state, state_n;
    logic [10:0] pend_x, pend_x_n, roi_x_n, addr_h_n, pan_x;
    logic [9:0]  pend_y, pend_y_n, roi_y_n, addr_v_n;
    logic        pan_left, pan_left_n, pan_flip, bank_n, ready_n, err_n;
    logic [7:0]  drop_n;
    logic [11:0] limit, sum;

    // Pan candidate computed in 12 bits so X0+STEP can never wrap before the clamp.
    always_comb begin
        limit    = 12'(SRC_WIDTH) - 12'(IMAGE_WIDTH);
        sum      = {1'b0, pend_x} + {8'd0, PAN_STEP};
        pan_x    = pend_x;
        pan_flip = 1'b0;
        if (!pan_left) begin
            if (sum > limit) begin
                pan_x    = limit[10:0];
                pan_flip = 1'b1;
            end else begin
                pan_x = sum[10:0];
            end
        end else begin
            if ({1'b0, pend_x} < {8'd0, PAN_STEP}) begin
                pan_x    = 11'd0;
                pan_flip = 1'b1;
            end else begin
                pan_x = pend_x - {7'd0, PAN_STEP};
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n    = state;
        addr_h_n   = ADDR_H;
        addr_v_n   = ADDR_V;
        roi_x_n    = ROI_X0;
        roi_y_n    = ROI_Y0;
        pend_x_n   = pend_x;
        pend_y_n   = pend_y;
        pan_left_n = pan_left;
        bank_n     = BANK_SEL;
        drop_n     = DROP_CNT;
        ready_n    = 1'b0;
        err_n      = 1'b0;
        case (state)
            IDLE: begin
                if (FRAME_START) begin
                    state_n = ACTIVE;
                    roi_y_n = pend_y;
                    if (PAN_EN) begin
                        roi_x_n  = pan_x;
                        pend_x_n = pan_x;
                        if (pan_flip) pan_left_n = ~pan_left;
                    end else begin
                        roi_x_n = pend_x;
                    end
                end
            end
            ACTIVE: begin
                if (FRAME_START) begin
                    // Restart: a coincident pixel becomes (0,0) of the new frame.
                    err_n    = 1'b1;
                    roi_x_n  = pend_x;
                    roi_y_n  = pend_y;
                    addr_h_n = PIX_VALID ? 11'd1 : 11'd0;
                    addr_v_n = 10'd0;
                end else if (PIX_VALID) begin
                    if (ADDR_H == 11'(SRC_WIDTH - 1)) begin
                        addr_h_n = 11'd0;
                        if (ADDR_V == 10'(SRC_HEIGHT - 1)) begin
                            addr_v_n = 10'd0;
                            state_n  = SWAP_WAIT;
                        end else begin
                            addr_v_n = ADDR_V + 10'd1;
                        end
                    end else begin
                        addr_h_n = ADDR_H + 11'd1;
                    end
                end
            end
            SWAP_WAIT: begin
                if (FRAME_START && DROP_CNT != 8'hFF) drop_n = DROP_CNT + 8'd1;
                if (BUF_RELEASE) begin
                    bank_n  = ~BANK_SEL;
                    ready_n = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        // Host writes take priority over the pan update of the pending origin.
        if (CFG_WE) begin
            pend_x_n = CFG_X0;
            pend_y_n = CFG_Y0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ADDR_H     <= '0;
            ADDR_V     <= '0;
            ROI_X0     <= '0;
            ROI_Y0     <= '0;
            pend_x     <= '0;
            pend_y     <= '0;
            pan_left   <= 1'b0;
            BANK_SEL   <= 1'b0;
            BANK_READY <= 1'b0;
            FRAME_ERR  <= 1'b0;
            DROP_CNT   <= '0;
        end else begin
            ADDR_H     <= addr_h_n;
            ADDR_V     <= addr_v_n;
            ROI_X0     <= roi_x_n;
            ROI_Y0     <= roi_y_n;
            pend_x     <= pend_x_n;
            pend_y     <= pend_y_n;
            pan_left   <= pan_left_n;
            BANK_SEL   <= bank_n;
            BANK_READY <= ready_n;
            FRAME_ERR  <= err_n;
            DROP_CNT   <= drop_n;
        end
    end

endmodule

// File: tb/tb_roi_sequencer.sv
// Bench for roi_sequencer: vector table, directed corner sequences and randomized
// traffic compared every cycle against a frame-level reference model.
module tb_roi_sequencer;

    localparam int W = 48;
    localparam int H = 2;

    logic        CLK = 1'b0;
    logic        RESET, FRAME_START, PIX_VALID, CFG_WE, PAN_EN, BUF_RELEASE;
    logic [5:0]  IMAGE_WIDTH;
    logic [10:0] CFG_X0;
    logic [9:0]  CFG_Y0;
    logic [3:0]  PAN_STEP;
    logic [10:0] ADDR_H, ROI_X0;
    logic [9:0]  ADDR_V, ROI_Y0;
    logic        BANK_SEL, BANK_READY, FRAME_ERR;
    logic [7:0]  DROP_CNT;

    always #5 CLK = ~CLK;

    roi_sequencer #(.SRC_WIDTH(W), .SRC_HEIGHT(H), .IMG_WIDTH_MAX_LOG2(6)) dut (
        .CLK(CLK), .RESET(RESET), .FRAME_START(FRAME_START), .PIX_VALID(PIX_VALID),
        .IMAGE_WIDTH(IMAGE_WIDTH), .CFG_X0(CFG_X0), .CFG_Y0(CFG_Y0), .CFG_WE(CFG_WE),
        .PAN_EN(PAN_EN), .PAN_STEP(PAN_STEP), .BUF_RELEASE(BUF_RELEASE),
        .ADDR_H(ADDR_H), .ADDR_V(ADDR_V), .ROI_X0(ROI_X0), .ROI_Y0(ROI_Y0),
        .BANK_SEL(BANK_SEL), .BANK_READY(BANK_READY), .FRAME_ERR(FRAME_ERR),
        .DROP_CNT(DROP_CNT)
    );

    int checks = 0;
    int failures = 0;
    int rdy_cnt = 0;

    // Reference model: frame phase, linear pixel index, pending/active origins.
    int m_mode;   // 0 waiting for frame, 1 capturing, 2 waiting for buffer
    int m_pix, m_bank, m_drop, m_px, m_py, m_rx, m_ry, m_err, m_rdy;
    bit m_left;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pix = 0; m_bank = 0; m_drop = 0;
        m_px = 0; m_py = 0; m_rx = 0; m_ry = 0; m_err = 0; m_rdy = 0; m_left = 0;
    endtask

    task automatic model_step();
        int lim, st;
        m_err = 0;
        m_rdy = 0;
        case (m_mode)
            0: if (FRAME_START) begin
                if (PAN_EN) begin
                    lim = W - int'(IMAGE_WIDTH);
                    st  = int'(PAN_STEP);
                    if (!m_left) begin
                        if (m_px + st > lim) begin m_px = lim; m_left = 1; end
                        else m_px = m_px + st;
                    end else begin
                        if (m_px < st) begin m_px = 0; m_left = 0; end
                        else m_px = m_px - st;
                    end
                end
                m_rx = m_px; m_ry = m_py; m_pix = 0; m_mode = 1;
            end
            1: if (FRAME_START) begin
                m_err = 1; m_rx = m_px; m_ry = m_py;
                m_pix = PIX_VALID ? 1 : 0;
            end else if (PIX_VALID) begin
                m_pix++;
                if (m_pix == W * H) begin m_pix = 0; m_mode = 2; end
            end
            default: begin
                if (FRAME_START && m_drop < 255) m_drop++;
                if (BUF_RELEASE) begin m_bank ^= 1; m_rdy = 1; m_mode = 0; end
            end
        endcase
        if (CFG_WE) begin m_px = int'(CFG_X0); m_py = int'(CFG_Y0); end
    endtask

    task automatic cmp_all();
        chk("addr_h", int'(ADDR_H), m_pix % W);
        chk("addr_v", int'(ADDR_V), m_pix / W);
        chk("roi_x0", int'(ROI_X0), m_rx);
        chk("roi_y0", int'(ROI_Y0), m_ry);
        chk("bank_sel", int'(BANK_SEL), m_bank);
        chk("bank_ready", int'(BANK_READY), m_rdy);
        chk("frame_err", int'(FRAME_ERR), m_err);
        chk("drop_cnt", int'(DROP_CNT), m_drop);
    endtask

    task automatic cyc(input logic fs, input logic pv, input logic rel);
        FRAME_START = fs; PIX_VALID = pv; BUF_RELEASE = rel;
        @(posedge CLK);
        model_step();
        #1;
        cmp_all();
        if (BANK_READY) rdy_cnt++;
        CFG_WE = 1'b0;
    endtask

    task automatic run_pixels(input int n, input logic rel);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, rel);
    endtask

    typedef struct {
        logic fs;
        logic pv;
        int   h;
        int   v;
        int   err;
    } vec_t;

    vec_t tbl[7];
    int   exp_pan[3];
    int   bank0;

    initial begin
        tbl[0] = '{1'b1, 1'b0, 0, 0, 0};
        tbl[1] = '{1'b0, 1'b1, 1, 0, 0};
        tbl[2] = '{1'b0, 1'b1, 2, 0, 0};
        tbl[3] = '{1'b0, 1'b0, 2, 0, 0};
        tbl[4] = '{1'b1, 1'b1, 1, 0, 1};
        tbl[5] = '{1'b1, 1'b0, 0, 0, 1};
        tbl[6] = '{1'b0, 1'b1, 1, 0, 0};
        exp_pan[0] = 16; exp_pan[1] = 16; exp_pan[2] = 8;

        RESET = 1'b1; FRAME_START = 0; PIX_VALID = 0; CFG_WE = 0; PAN_EN = 0;
        BUF_RELEASE = 0; IMAGE_WIDTH = 6'd32; CFG_X0 = 0; CFG_Y0 = 0; PAN_STEP = 0;
        model_reset();
        #12;
        chk("rst_addr_h", int'(ADDR_H), 0);
        chk("rst_bank_sel", int'(BANK_SEL), 0);
        chk("rst_drop", int'(DROP_CNT), 0);
        chk("rst_roi_x", int'(ROI_X0), 0);
        RESET = 1'b0;

        // Vector table: start, count, restart with and without coincident pixel.
        for (int i = 0; i < 7; i++) begin
            cyc(tbl[i].fs, tbl[i].pv, 1'b0);
            chk("tbl_h", int'(ADDR_H), tbl[i].h);
            chk("tbl_v", int'(ADDR_V), tbl[i].v);
            chk("tbl_err", int'(FRAME_ERR), tbl[i].err);
        end

        // Restart at (10,1) mid-frame.
        run_pixels(W + 9, 1'b0);
        chk("pos_h", int'(ADDR_H), 10);
        chk("pos_v", int'(ADDR_V), 1);
        cyc(1'b1, 1'b0, 1'b0);
        chk("restart_err", int'(FRAME_ERR), 1);
        chk("restart_h", int'(ADDR_H), 0);
        chk("restart_v", int'(ADDR_V), 0);

        // Asynchronous reset mid-frame.
        run_pixels(5, 1'b0);
        #3 RESET = 1'b1;
        #1;
        chk("amid_rst_h", int'(ADDR_H), 0);
        chk("amid_rst_roi", int'(ROI_X0), 0);
        chk("amid_rst_err", int'(FRAME_ERR), 0);
        model_reset();
        #2 RESET = 1'b0;

        // Full frame with buffer released: single swap.
        rdy_cnt = 0;
        cyc(1'b1, 1'b0, 1'b1);
        run_pixels(W * H, 1'b1);
        chk("frame_end_h", int'(ADDR_H), 0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("swap_bank", int'(BANK_SEL), 1);
        cyc(1'b0, 1'b0, 1'b1);
        chk("swap_ready_cnt", rdy_cnt, 1);

        // Config written mid-frame takes effect only at the next frame start.
        cyc(1'b1, 1'b0, 1'b0);
        CFG_X0 = 11'd100; CFG_Y0 = 10'd50; CFG_WE = 1'b1;
        cyc(1'b0, 1'b1, 1'b0);
        run_pixels(4, 1'b0);
        chk("cfg_hold_x", int'(ROI_X0), 0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("cfg_new_x", int'(ROI_X0), 100);
        chk("cfg_new_y", int'(ROI_Y0), 50);
        run_pixels(W * H, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);

        // Auto-pan clamp at LIMIT = 48-32 = 16 and reverse.
        CFG_X0 = 11'd8; CFG_WE = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        PAN_EN = 1'b1; PAN_STEP = 4'd8; IMAGE_WIDTH = 6'd32;
        for (int f = 0; f < 3; f++) begin
            cyc(1'b1, 1'b0, 1'b0);
            chk("pan_x", int'(ROI_X0), exp_pan[f]);
            run_pixels(W * H, 1'b1);
            cyc(1'b0, 1'b0, 1'b1);
        end
        PAN_EN = 1'b0;

        // Drops while the buffer is held, then saturation.
        bank0 = int'(BANK_SEL);
        cyc(1'b1, 1'b0, 1'b0);
        run_pixels(W * H, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0);
        chk("drop3", int'(DROP_CNT), 3);
        chk("drop_bank", int'(BANK_SEL), bank0);
        for (int i = 0; i < 260; i++) cyc(1'b1, 1'b0, 1'b0);
        chk("drop_sat", int'(DROP_CNT), 255);
        cyc(1'b1, 1'b0, 1'b1);
        chk("drop_swap_bank", int'(BANK_SEL), 1 - bank0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            logic fs;
            fs = ($urandom_range(0, 120) == 0);
            if (i % 500 == 0) begin
                PAN_EN      = 1'($urandom_range(0, 1));
                PAN_STEP    = 4'($urandom_range(0, 15));
                IMAGE_WIDTH = 6'($urandom_range(0, 40));
            end
            if (!fs && $urandom_range(0, 60) == 0) begin
                CFG_X0 = 11'($urandom_range(0, 47));
                CFG_Y0 = 10'($urandom_range(0, 1023));
                CFG_WE = 1'b1;
            end
            cyc(fs, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
